usb_seq: RTL and testbench

Hardware transaction sequencer for the USB device core. Sole master of the core's register bus: services its interrupts, answers tokens with DATA0/DATA1, ACK or NAK handshakes, programs DMA, and tracks data toggles. The b16 CPU sees only four sequencer registers plus a level interrupt.

---
 rtl/usb_seq.sv | 242 ++++++++++++++++++++++++
 tb/tb_usb_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_seq.sv
// usb_seq: transaction sequencer that owns the USB device core register bus,
// answers tokens with data packets or handshakes, and exposes four CPU registers.
module usb_seq #(
  parameter logic [9:0] MAXPKT = 10'd66,
  parameter logic [9:0] HSTO   = 10'd400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        r,
  input  logic [1:0]  addr,
  input  logic [1:0]  w,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        intreq,
  output logic        usel,
  output logic        ur,
  output logic [1:0]  uaddr,
  output logic [1:0]  uw,
  output logic [15:0] udout,
  input  logic [15:0] udin,
  input  logic        uint,
  output logic        uintack
);

  typedef enum logic [2:0] {
    S_IDLE, S_STAT, S_WDMA, S_WCMD, S_RDLEN, S_WSENT, S_WHS
  } state_t;

  localparam logic [15:0] CMD_ACK = 16'h2800;
  localparam logic [15:0] CMD_NAK = 16'hA800;

  state_t      state_reg, state_next;
  logic [15:0] cmd_reg, cmd_next;
  logic        dma_tx_reg, dma_tx_next;
  logic        sent_reg, sent_next;
  logic        in_data_reg, in_data_next;
  logic        from_whs_reg;
  logic [9:0]  hs_cnt_reg;
  logic        txarm_reg, rxarm_reg, txtog_reg, rxtog_reg;
  logic        setup_reg, rxdone_reg, txdone_reg, setup_rx_reg;
  logic [15:0] txaddr_reg, rxaddr_reg;
  logic [9:0]  txlen_reg, rxlen_reg;
  logic        hw_setup, hw_rx_accept, hw_tx_ack;
  logic [3:0]  spid;
  logic        sok;
  logic        wr_lo, wr_hi;
  logic        unused_ok;

  assign spid      = udin[15:12];
  assign sok       = udin[11];
  assign wr_lo     = sel & w[0];
  assign wr_hi     = sel & w[1];
  assign intreq    = txdone_reg | rxdone_reg | setup_reg;
  assign unused_ok = ^{r, udin[10]};

  always_comb begin
    dout = 16'h0000;
    if (sel) begin
      case (addr)
        2'd0: dout = {state_reg, 6'b0, setup_reg, rxdone_reg, txdone_reg,
                      rxtog_reg, txtog_reg, rxarm_reg, txarm_reg};
        2'd1: dout = txaddr_reg;
        2'd2: dout = rxaddr_reg;
        default: dout = {6'b0, rxlen_reg};
      endcase
    end
  end

  always_comb begin
    state_next   = state_reg;
    cmd_next     = cmd_reg;
    dma_tx_next  = dma_tx_reg;
    sent_next    = sent_reg;
    in_data_next = in_data_reg;
    usel         = 1'b0;
    ur           = 1'b0;
    uw           = 2'b00;
    uaddr        = 2'd0;
    udout        = 16'h0000;
    uintack      = 1'b0;
    hw_setup     = 1'b0;
    hw_rx_accept = 1'b0;
    hw_tx_ack    = 1'b0;
    case (state_reg)
      S_IDLE: if (uint) state_next = S_STAT;
      S_STAT: begin
        usel       = 1'b1;
        ur         = 1'b1;
        uintack    = 1'b1;
        state_next = S_IDLE;
        if (from_whs_reg && spid == 4'b0010 && sok) begin
          hw_tx_ack = txarm_reg;
        end else if (spid[2:0] == 3'b011) begin
          if (sok) begin
            sent_next    = 1'b1;
            in_data_next = 1'b0;
            if (rxarm_reg || setup_rx_reg) begin
              cmd_next   = CMD_ACK;
              // a toggle mismatch is a retransmission: acknowledge, keep the old data
              state_next = (spid[3] == rxtog_reg) ? S_RDLEN : S_WCMD;
            end else begin
              cmd_next   = CMD_NAK;
              state_next = S_WCMD;
            end
          end
        end else if (spid == 4'b0001 || spid == 4'b1101) begin
          hw_setup     = (spid == 4'b1101);
          cmd_next     = {6'b0, MAXPKT};
          dma_tx_next  = 1'b0;
          sent_next    = 1'b0;
          in_data_next = 1'b0;
          state_next   = S_WDMA;
        end else if (spid == 4'b1001) begin
          sent_next = 1'b1;
          if (txarm_reg) begin
            cmd_next     = {txtog_reg, 3'b011, 1'b1, 1'b0, txlen_reg};
            dma_tx_next  = 1'b1;
            in_data_next = 1'b1;
            state_next   = S_WDMA;
          end else begin
            cmd_next     = CMD_NAK;
            in_data_next = 1'b0;
            state_next   = S_WCMD;
          end
        end
      end
      S_WDMA: begin
        usel       = 1'b1;
        uw         = 2'b11;
        uaddr      = 2'd2;
        udout      = dma_tx_reg ? txaddr_reg : rxaddr_reg;
        state_next = S_WCMD;
      end
      S_WCMD: begin
        usel       = 1'b1;
        uw         = 2'b11;
        uaddr      = 2'd0;
        udout      = cmd_reg;
        state_next = sent_reg ? S_WSENT : S_IDLE;
      end
      S_RDLEN: begin
        usel         = 1'b1;
        ur           = 1'b1;
        uaddr        = 2'd2;
        hw_rx_accept = 1'b1;
        state_next   = S_WCMD;
      end
      S_WSENT: begin
        if (uint) begin
          usel       = 1'b1;
          ur         = 1'b1;
          uintack    = 1'b1;
          state_next = in_data_reg ? S_WHS : S_IDLE;
        end
      end
      S_WHS: begin
        if (uint)                    state_next = S_STAT;
        else if (hs_cnt_reg == 10'd0) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      cmd_reg      <= 16'h0000;
      dma_tx_reg   <= 1'b0;
      sent_reg     <= 1'b0;
      in_data_reg  <= 1'b0;
      from_whs_reg <= 1'b0;
      hs_cnt_reg   <= 10'd0;
    end else begin
      state_reg   <= state_next;
      cmd_reg     <= cmd_next;
      dma_tx_reg  <= dma_tx_next;
      sent_reg    <= sent_next;
      in_data_reg <= in_data_next;
      // STAT lasts one cycle, so this records where it was entered from
      if (state_reg != S_STAT) from_whs_reg <= (state_reg == S_WHS);
      if (state_reg == S_WSENT && state_next == S_WHS)
        hs_cnt_reg <= HSTO;
      else if (state_reg == S_WHS && hs_cnt_reg != 10'd0)
        hs_cnt_reg <= hs_cnt_reg - 10'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txarm_reg    <= 1'b0;
      rxarm_reg    <= 1'b0;
      txtog_reg    <= 1'b0;
      rxtog_reg    <= 1'b0;
      setup_reg    <= 1'b0;
      rxdone_reg   <= 1'b0;
      txdone_reg   <= 1'b0;
      setup_rx_reg <= 1'b0;
      txaddr_reg   <= 16'h0000;
      rxaddr_reg   <= 16'h0000;
      txlen_reg    <= 10'd0;
      rxlen_reg    <= 10'd0;
    end else begin
      if (wr_lo && addr == 2'd0 && din[0])      txarm_reg <= 1'b1;
      else if (wr_hi && addr == 2'd0 && din[8]) txarm_reg <= 1'b0;
      else if (hw_tx_ack)                       txarm_reg <= 1'b0;

      if (wr_lo && addr == 2'd0 && din[1])      rxarm_reg <= 1'b1;
      else if (wr_hi && addr == 2'd0 && din[9]) rxarm_reg <= 1'b0;
      else if (hw_rx_accept)                    rxarm_reg <= 1'b0;

      if (hw_tx_ack)                     txtog_reg <= ~txtog_reg;
      else if (hw_setup)                 txtog_reg <= 1'b1;
      else if (wr_lo && addr == 2'd0)    txtog_reg <= din[2];

      if (hw_rx_accept)                  rxtog_reg <= ~rxtog_reg;
      else if (hw_setup)                 rxtog_reg <= 1'b0;
      else if (wr_lo && addr == 2'd0)    rxtog_reg <= din[3];

      // hardware set wins over a simultaneous write-1-clear
      if (hw_setup)                              setup_reg  <= 1'b1;
      else if (wr_lo && addr == 2'd0 && din[6])  setup_reg  <= 1'b0;
      if (hw_rx_accept)                          rxdone_reg <= 1'b1;
      else if (wr_lo && addr == 2'd0 && din[5])  rxdone_reg <= 1'b0;
      if (hw_tx_ack)                             txdone_reg <= 1'b1;
      else if (wr_lo && addr == 2'd0 && din[4])  txdone_reg <= 1'b0;

      if (hw_setup)          setup_rx_reg <= 1'b1;
      else if (hw_rx_accept) setup_rx_reg <= 1'b0;

      if (hw_rx_accept) rxlen_reg <= udin[9:0] - rxaddr_reg[9:0];

      if (wr_lo && addr == 2'd1) txaddr_reg[7:0]  <= din[7:0];
      if (wr_hi && addr == 2'd1) txaddr_reg[15:8] <= din[15:8];
      if (wr_lo && addr == 2'd2) rxaddr_reg[7:0]  <= din[7:0];
      if (wr_hi && addr == 2'd2) rxaddr_reg[15:8] <= din[15:8];
      if (wr_lo && addr == 2'd3) txlen_reg[7:0]   <= din[7:0];
      if (wr_hi && addr == 2'd3) txlen_reg[9:8]   <= din[9:8];
    end
  end

endmodule

// File: tb/tb_usb_seq.sv
// tb_usb_seq: scoreboard bench for usb_seq; a small core model answers reads and
// every core write is checked against the queued expectation, data and cycle.
module tb_usb_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0, r = 1'b0;
  logic [1:0]  addr = 2'd0, w = 2'b00;
  logic [15:0] din = 16'h0000;
  logic [15:0] dout;
  logic        intreq, usel, ur, uintack;
  logic [1:0]  uaddr, uw;
  logic [15:0] udout, udin;
  logic        uint = 1'b0;
  logic [15:0] core_stat = 16'h0000, core_dma = 16'h0000;

  typedef struct {
    logic [1:0]  a;
    logic [15:0] d;
    int          c;
  } wr_t;

  wr_t sbq[$];
  int  cyc = 0;
  int  n_vec = 0;
  int  n_bad = 0;

  usb_seq dut (
    .clk(clk), .reset(reset), .sel(sel), .r(r), .addr(addr), .w(w), .din(din),
    .dout(dout), .intreq(intreq), .usel(usel), .ur(ur), .uaddr(uaddr), .uw(uw),
    .udout(udout), .udin(udin), .uint(uint), .uintack(uintack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign udin = (uaddr == 2'd2) ? core_dma : core_stat;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: %h (cycle %0d)", tag, got, cyc);
    end
  endtask

  // core write monitor: every write must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset && usel && uw != 2'b00) begin
      if (sbq.size() == 0) begin
        check_val("extra_wr", {12'h0, uw, uaddr, udout}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sbq.pop_front();
        check_val("core_wr", {12'h0, uw, uaddr, udout}, {12'h0, 2'b11, e.a, e.d});
        check_val("core_wr_cyc", cyc, e.c);
      end
    end
  end

  task automatic push_wr(input logic [1:0] a, input logic [15:0] d, input int off);
    wr_t e;
    e.a = a;
    e.d = d;
    e.c = cyc + off;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [1:0] lanes, input logic [15:0] d);
    sel = 1'b1; addr = a; w = lanes; din = d;
    @(negedge clk);
    sel = 1'b0; w = 2'b00; din = 16'h0000;
  endtask

  task automatic cpu_rd(input string tag, input logic [1:0] a, input logic [15:0] exp);
    sel = 1'b1; r = 1'b1; addr = a;
    #1;
    check_val(tag, {16'h0, dout}, {16'h0, exp});
    sel = 1'b0; r = 1'b0;
    @(negedge clk);
  endtask

  // raise the core interrupt with the given status, hold until acknowledged
  task automatic pkt(input logic [3:0] pid, input logic ok, input logic [15:0] dma);
    int n = 0;
    core_stat = {pid, ok, 11'h000};
    core_dma  = dma;
    uint      = 1'b1;
    #1;
    while (!uintack && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_val("uint_ack_seen", {31'h0, uintack}, 32'h1);
    @(posedge clk);
    #1 uint = 1'b0;
    @(negedge clk);
    check_val("ack_pulse", {31'h0, uintack}, 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_bus", {12'h0, usel, ur, uw, uintack, udout}, 32'h0);
    check_val("rst_intreq", {31'h0, intreq}, 32'h0);
    reset = 1'b1;
    idle(1);
    cpu_rd("rst_status", 2'd0, 16'h0000);

    // setup: txaddr, txlen, rxaddr, arm both directions, toggles 0
    cpu_wr(2'd1, 2'b11, 16'h1000);
    cpu_wr(2'd3, 2'b11, 16'h0008);
    cpu_wr(2'd2, 2'b11, 16'h2000);
    cpu_wr(2'd0, 2'b01, 16'h0003);
    cpu_rd("armed", 2'd0, 16'h0003);
    cpu_rd("txaddr", 2'd1, 16'h1000);

    // IN with txarm, sent, then host ACK
    push_wr(2'd2, 16'h1000, 2);
    push_wr(2'd0, 16'h3808, 3);
    pkt(4'b1001, 1'b1, 16'h0000);
    idle(3);
    pkt(4'b0000, 1'b0, 16'h0000);
    pkt(4'b0010, 1'b1, 16'h0000);
    idle(2);
    cpu_rd("in_acked", 2'd0, 16'h0016);
    check_val("intreq_tx", {31'h0, intreq}, 32'h1);
    cpu_wr(2'd0, 2'b01, 16'h0014);
    cpu_rd("txdone_clr", 2'd0, 16'h0006);
    check_val("intreq_clr", {31'h0, intreq}, 32'h0);

    // IN without txarm -> NAK only
    push_wr(2'd0, 16'hA800, 2);
    pkt(4'b1001, 1'b1, 16'h0000);
    idle(3);
    pkt(4'b0000, 1'b0, 16'h0000);
    idle(2);
    cpu_rd("in_nak", 2'd0, 16'h0006);

    // OUT then DATA0 accepted with 10 bytes
    push_wr(2'd2, 16'h2000, 2);
    push_wr(2'd0, 16'h0042, 3);
    pkt(4'b0001, 1'b1, 16'h0000);
    idle(3);
    push_wr(2'd0, 16'h2800, 3);
    pkt(4'b0011, 1'b1, 16'h200A);
    idle(3);
    pkt(4'b0000, 1'b0, 16'h0000);
    idle(2);
    cpu_rd("data0_acc", 2'd0, 16'h002C);
    cpu_rd("rxlen10", 2'd3, 16'h000A);

    // re-arm with rxtog=0, DATA1 is a duplicate: ACK only
    cpu_wr(2'd0, 2'b01, 16'h0026);
    cpu_rd("rearm", 2'd0, 16'h0006);
    push_wr(2'd0, 16'h2800, 2);
    pkt(4'b1011, 1'b1, 16'h2010);
    idle(3);
    pkt(4'b0000, 1'b0, 16'h0000);
    idle(2);
    cpu_rd("dup_data", 2'd0, 16'h0006);
    cpu_rd("rxlen_kept", 2'd3, 16'h000A);

    // cancel rxarm, SETUP then DATA0 accepted through setup_rx
    cpu_wr(2'd0, 2'b10, 16'h0200);
    cpu_rd("rx_cancel", 2'd0, 16'h0004);
    push_wr(2'd2, 16'h2000, 2);
    push_wr(2'd0, 16'h0042, 3);
    pkt(4'b1101, 1'b1, 16'h0000);
    idle(3);
    cpu_rd("setup", 2'd0, 16'h0044);
    check_val("intreq_setup", {31'h0, intreq}, 32'h1);
    push_wr(2'd0, 16'h2800, 3);
    pkt(4'b0011, 1'b1, 16'h2004);
    idle(3);
    pkt(4'b0000, 1'b0, 16'h0000);
    idle(2);
    cpu_rd("setup_data", 2'd0, 16'h006C);
    cpu_rd("rxlen4", 2'd3, 16'h0004);

    // IN with txtog=1, host never ACKs -> timeout, resend same PID
    cpu_wr(2'd0, 2'b01, 16'h007D);
    cpu_rd("tx_rearm", 2'd0, 16'h000D);
    push_wr(2'd2, 16'h1000, 2);
    push_wr(2'd0, 16'hB808, 3);
    pkt(4'b1001, 1'b1, 16'h0000);
    idle(3);
    pkt(4'b0000, 1'b0, 16'h0000);
    cpu_rd("in_whs", 2'd0, 16'hC00D);
    idle(420);
    cpu_rd("hs_timeout", 2'd0, 16'h000D);
    push_wr(2'd2, 16'h1000, 2);
    push_wr(2'd0, 16'hB808, 3);
    pkt(4'b1001, 1'b1, 16'h0000);
    idle(3);
    pkt(4'b0000, 1'b0, 16'h0000);
    pkt(4'b0010, 1'b1, 16'h0000);
    idle(2);
    cpu_rd("retry_acked", 2'd0, 16'h0018);

    // asynchronous reset in the STAT cycle: no further core access
    cpu_wr(2'd0, 2'b01, 16'h0001);
    core_stat = 16'h9800;
    uint = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_val("abort_bus", {12'h0, usel, ur, uw, uintack, udout}, 32'h0);
    uint = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(2);
    cpu_rd("abort_status", 2'd0, 16'h0000);
    check_val("abort_intreq", {31'h0, intreq}, 32'h0);
    check_val("sb_left", sbq.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
